mem_req_initiator: RTL and testbench

// - Processor-side initiator for the fixed-latency, no-backpressure, in-order memory request/response interface.
// - Arbitrates instruction-fetch (IF) and load/store (DM) client requests onto the single memory request port, one per cycle.
// - Tracks outstanding reads per client; routes tagged responses (is_instr) back to the owning client.

---
 rtl/params_pkg.sv | 20 ++
 rtl/mem_req_initiator_if.sv | 69 ++++++
 rtl/mem_req_initiator_credit.sv | 39 +++
 rtl/mem_req_initiator.sv | 202 ++++++++++++++++++++
 tb/tb_mem_req_initiator.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/params_pkg.sv
// Shared widths, access-size and arbitration types for the memory request initiator.
// MEM_RSP_TIMEOUT is the default watchdog limit used when MEM_RSP_TIMEOUT_EN is defined.
package params_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int DATA_WIDTH      = 32;
  localparam int MEM_RSP_TIMEOUT = 32;

  typedef enum logic [0:0] {
    BYTE = 1'b0,
    WORD = 1'b1
  } access_size_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } arb_grant_t;

endpackage

// File: rtl/mem_req_initiator_if.sv
// Client, memory and debug signals of mem_req_initiator; master = initiator side,
// slave = the clients plus the memory model driving the initiator's inputs.
interface mem_req_initiator_if #(
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH
);
  import params_pkg::*;

  // A client request is taken in the cycle where its valid and ready are both high;
  // ready is a same-cycle answer to valid, so a client may drop or change its request
  // freely in any cycle where ready was low. Memory side has no backpressure at all.
  logic                  if_req_valid_i;
  logic                  if_req_ready_o;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_rsp_valid_o;
  logic [DATA_WIDTH-1:0] if_rsp_data_o;

  logic                  dm_req_valid_i;
  logic                  dm_req_ready_o;
  logic                  dm_req_is_wr_i;
  logic [ADDR_WIDTH-1:0] dm_addr_i;
  logic [DATA_WIDTH-1:0] dm_wr_data_i;
  access_size_t          dm_access_size_i;
  logic                  dm_rsp_valid_o;
  logic [DATA_WIDTH-1:0] dm_rsp_data_o;

  logic                  mem_rd_req_valid_o;
  logic                  mem_wr_req_valid_o;
  logic                  mem_req_is_instr_o;
  logic [ADDR_WIDTH-1:0] mem_address_o;
  logic [DATA_WIDTH-1:0] mem_wr_data_o;
  access_size_t          mem_access_size_o;
  logic                  mem_data_valid_i;
  logic                  mem_data_is_instr_i;
  logic [DATA_WIDTH-1:0] mem_data_i;

  logic                  err_o;

  // Observation of the arbiter and credit state
  arb_grant_t            gnt_dbg;
  logic [7:0]            if_cnt_dbg;
  logic [7:0]            dm_cnt_dbg;
  logic [7:0]            starve_dbg;

  modport master (
    input  if_req_valid_i, if_addr_i,
    output if_req_ready_o, if_rsp_valid_o, if_rsp_data_o,
    input  dm_req_valid_i, dm_req_is_wr_i, dm_addr_i, dm_wr_data_i, dm_access_size_i,
    output dm_req_ready_o, dm_rsp_valid_o, dm_rsp_data_o,
    output mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
    output mem_address_o, mem_wr_data_o, mem_access_size_o,
    input  mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
    output err_o,
    output gnt_dbg, if_cnt_dbg, dm_cnt_dbg, starve_dbg
  );

  modport slave (
    output if_req_valid_i, if_addr_i,
    input  if_req_ready_o, if_rsp_valid_o, if_rsp_data_o,
    output dm_req_valid_i, dm_req_is_wr_i, dm_addr_i, dm_wr_data_i, dm_access_size_i,
    input  dm_req_ready_o, dm_rsp_valid_o, dm_rsp_data_o,
    input  mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
    input  mem_address_o, mem_wr_data_o, mem_access_size_o,
    output mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
    input  err_o,
    input  gnt_dbg, if_cnt_dbg, dm_cnt_dbg, starve_dbg
  );

endinterface

// File: rtl/mem_req_initiator_credit.sv
// Up/down saturating counter of in-flight reads for one client, with full and zero flags.
module mem_credit_cnt #(
  parameter  int MAX_COUNT = 10,
  localparam int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          zero_o
);

  logic [CW-1:0] count_d, count_q;

  // inc and dec together cancel, so a slot freed and refilled in one cycle holds the count
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != CW'(MAX_COUNT))) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(MAX_COUNT));
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/mem_req_initiator.sv
// Arbitrates IF and DM requests onto the single memory port and routes tagged responses back.
// Define MEM_RSP_TIMEOUT_EN to add a response watchdog that also raises err_o.
module mem_req_initiator #(
  parameter int ADDR_WIDTH      = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH      = params_pkg::DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 10,
  parameter int STARVE_LIMIT    = 4,
  parameter int TIMEOUT_CYCLES  = params_pkg::MEM_RSP_TIMEOUT
) (
  input logic                 clk_i,
  input logic                 rst_i,
  mem_req_initiator_if.master bus
);
  import params_pkg::*;

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 2);

  logic [CW-1:0] if_cnt, dm_cnt;
  logic          if_full, if_zero, dm_full, dm_zero;
  logic          if_rsp_in, dm_rsp_in, if_rsp_ok, dm_rsp_ok, unexpected;
  logic          if_elig, dm_elig, force_if;
  logic          wd_expire;
  arb_grant_t    gnt;

  logic [SW-1:0]         starve_d, starve_q;
  logic                  rd_d, rd_q, wr_d, wr_q, instr_d, instr_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
  access_size_t          size_d, size_q;
  logic                  if_rsp_v_d, if_rsp_v_q, dm_rsp_v_d, dm_rsp_v_q;
  logic [DATA_WIDTH-1:0] if_rsp_data_d, if_rsp_data_q, dm_rsp_data_d, dm_rsp_data_q;
  logic                  err_d, err_q;

  assign if_rsp_in  = bus.mem_data_valid_i &&  bus.mem_data_is_instr_i;
  assign dm_rsp_in  = bus.mem_data_valid_i && !bus.mem_data_is_instr_i;
  assign if_rsp_ok  = if_rsp_in && !if_zero;
  assign dm_rsp_ok  = dm_rsp_in && !dm_zero;
  assign unexpected = (if_rsp_in && if_zero) || (dm_rsp_in && dm_zero);

  // A response retiring a read in this cycle frees its slot for a new read in the same cycle
  assign if_elig  = !if_full || if_rsp_ok;
  assign dm_elig  = bus.dm_req_is_wr_i || !dm_full || dm_rsp_ok;
  assign force_if = (starve_q == SW'(STARVE_LIMIT)) && bus.if_req_valid_i && if_elig;

  always_comb begin
    gnt = GNT_NONE;
    if (!rst_i) begin
      if (force_if) begin
        gnt = GNT_IF;
      end else if (bus.dm_req_valid_i && dm_elig) begin
        gnt = GNT_DM;
      end else if (bus.if_req_valid_i && if_elig) begin
        gnt = GNT_IF;
      end
    end
  end

  assign bus.if_req_ready_o = (gnt == GNT_IF);
  assign bus.dm_req_ready_o = (gnt == GNT_DM);

  mem_credit_cnt #(.MAX_COUNT(MAX_OUTSTANDING)) u_if_credit (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (gnt == GNT_IF),
    .dec_i   (if_rsp_ok),
    .count_o (if_cnt),
    .full_o  (if_full),
    .zero_o  (if_zero)
  );

  mem_credit_cnt #(.MAX_COUNT(MAX_OUTSTANDING)) u_dm_credit (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   ((gnt == GNT_DM) && !bus.dm_req_is_wr_i),
    .dec_i   (dm_rsp_ok),
    .count_o (dm_cnt),
    .full_o  (dm_full),
    .zero_o  (dm_zero)
  );

  always_comb begin
    starve_d = starve_q;
    if ((gnt == GNT_DM) && bus.if_req_valid_i) begin
      if (starve_q != SW'(STARVE_LIMIT)) begin
        starve_d = starve_q + 1'b1;
      end
    end else if ((gnt == GNT_IF) || !bus.if_req_valid_i) begin
      starve_d = '0;
    end
  end

  // Address/data/size hold their last value between issues; only the valids pulse
  always_comb begin
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    instr_d = instr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    case (gnt)
      GNT_IF: begin
        rd_d    = 1'b1;
        instr_d = 1'b1;
        addr_d  = bus.if_addr_i;
        size_d  = WORD;
      end
      GNT_DM: begin
        rd_d    = !bus.dm_req_is_wr_i;
        wr_d    = bus.dm_req_is_wr_i;
        instr_d = 1'b0;
        addr_d  = bus.dm_addr_i;
        wdata_d = bus.dm_wr_data_i;
        size_d  = bus.dm_access_size_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    if_rsp_v_d    = if_rsp_ok;
    dm_rsp_v_d    = dm_rsp_ok;
    if_rsp_data_d = if_rsp_ok ? bus.mem_data_i : if_rsp_data_q;
    dm_rsp_data_d = dm_rsp_ok ? bus.mem_data_i : dm_rsp_data_q;
    err_d         = err_q || unexpected || wd_expire;
  end

`ifdef MEM_RSP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_d, wd_q;

  // Any response, even a dropped one, shows the memory is alive and restarts the count
  always_comb begin
    wd_d = wd_q;
    if (bus.mem_data_valid_i || (if_zero && dm_zero)) begin
      wd_d = '0;
    end else if (wd_q != TW'(TIMEOUT_CYCLES)) begin
      wd_d = wd_q + 1'b1;
    end
    wd_expire = (wd_d == TW'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  // No watchdog in this build; the limit only matters when it is compiled in
  assign wd_expire = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q      <= '0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      instr_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      size_q        <= WORD;
      if_rsp_v_q    <= 1'b0;
      dm_rsp_v_q    <= 1'b0;
      if_rsp_data_q <= '0;
      dm_rsp_data_q <= '0;
      err_q         <= 1'b0;
    end else begin
      starve_q      <= starve_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      instr_q       <= instr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      size_q        <= size_d;
      if_rsp_v_q    <= if_rsp_v_d;
      dm_rsp_v_q    <= dm_rsp_v_d;
      if_rsp_data_q <= if_rsp_data_d;
      dm_rsp_data_q <= dm_rsp_data_d;
      err_q         <= err_d;
    end
  end

  assign bus.mem_rd_req_valid_o = rd_q;
  assign bus.mem_wr_req_valid_o = wr_q;
  assign bus.mem_req_is_instr_o = instr_q;
  assign bus.mem_address_o      = addr_q;
  assign bus.mem_wr_data_o      = wdata_q;
  assign bus.mem_access_size_o  = size_q;
  assign bus.if_rsp_valid_o     = if_rsp_v_q;
  assign bus.if_rsp_data_o      = if_rsp_data_q;
  assign bus.dm_rsp_valid_o     = dm_rsp_v_q;
  assign bus.dm_rsp_data_o      = dm_rsp_data_q;
  assign bus.err_o              = err_q;

  assign bus.gnt_dbg    = gnt;
  assign bus.if_cnt_dbg = 8'(if_cnt);
  assign bus.dm_cnt_dbg = 8'(dm_cnt);
  assign bus.starve_dbg = 8'(starve_q);

endmodule

// File: tb/tb_mem_req_initiator.sv
// Self-checking bench for mem_req_initiator: directed cases plus a randomized phase,
// all outputs compared every cycle against a behavioural model of the initiator.
module tb_mem_req_initiator;
  import params_pkg::*;

  localparam int AW     = params_pkg::ADDR_WIDTH;
  localparam int DW     = params_pkg::DATA_WIDTH;
  localparam int MAXO   = 10;
  localparam int STARVE = 4;
  localparam int TOUT   = 32;
  localparam int QW     = 4 + AW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errs   = 0;

  always #5 clk = ~clk;

  mem_req_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_req_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO),
    .STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              m_if, m_dm, m_starve, m_wd;
  bit              m_err;
  logic [QW-1:0]   exp_q[$];   // {rd, wr, is_instr, size, addr, wdata} issued next cycle
  bit              exp_if_v, exp_dm_v;
  logic [DW-1:0]   exp_if_d, exp_dm_d;

  always @(negedge clk) begin
    logic [QW-1:0] e;
    bit if_hit, dm_hit, if_ok, dm_ok, gif, gdm;
    arb_grant_t g;
    if (rst) begin
      chk("rst_if_ready", bus.if_req_ready_o, 0);
      chk("rst_dm_ready", bus.dm_req_ready_o, 0);
      chk("rst_rd_valid", bus.mem_rd_req_valid_o, 0);
      chk("rst_wr_valid", bus.mem_wr_req_valid_o, 0);
      chk("rst_if_rsp", bus.if_rsp_valid_o, 0);
      chk("rst_dm_rsp", bus.dm_rsp_valid_o, 0);
      chk("rst_err", bus.err_o, 0);
      chk("rst_addr", bus.mem_address_o, 0);
      chk("rst_size", bus.mem_access_size_o, WORD);
      chk("rst_if_cnt", bus.if_cnt_dbg, 0);
      chk("rst_dm_cnt", bus.dm_cnt_dbg, 0);
      chk("rst_starve", bus.starve_dbg, 0);
      m_if = 0; m_dm = 0; m_starve = 0; m_wd = 0; m_err = 0;
      exp_q.delete();
      exp_if_v = 0; exp_dm_v = 0;
    end else begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("issue_rd", bus.mem_rd_req_valid_o, e[QW-1]);
        chk("issue_wr", bus.mem_wr_req_valid_o, e[QW-2]);
        chk("issue_instr", bus.mem_req_is_instr_o, e[QW-3]);
        chk("issue_size", bus.mem_access_size_o, e[QW-4]);
        chk("issue_addr", bus.mem_address_o, e[AW+DW-1:DW]);
        if (e[QW-2]) chk("issue_wdata", bus.mem_wr_data_o, e[DW-1:0]);
      end else begin
        chk("idle_rd", bus.mem_rd_req_valid_o, 0);
        chk("idle_wr", bus.mem_wr_req_valid_o, 0);
      end
      chk("if_rsp_valid", bus.if_rsp_valid_o, exp_if_v);
      if (exp_if_v) chk("if_rsp_data", bus.if_rsp_data_o, exp_if_d);
      chk("dm_rsp_valid", bus.dm_rsp_valid_o, exp_dm_v);
      if (exp_dm_v) chk("dm_rsp_data", bus.dm_rsp_data_o, exp_dm_d);
      chk("err", bus.err_o, m_err);
      chk("if_cnt", bus.if_cnt_dbg, m_if);
      chk("dm_cnt", bus.dm_cnt_dbg, m_dm);
      chk("starve", bus.starve_dbg, m_starve);

      // who may be granted this cycle
      if_hit = bus.mem_data_valid_i && bus.mem_data_is_instr_i && (m_if > 0);
      dm_hit = bus.mem_data_valid_i && !bus.mem_data_is_instr_i && (m_dm > 0);
      if_ok  = (m_if < MAXO) || if_hit;
      dm_ok  = bus.dm_req_is_wr_i || (m_dm < MAXO) || dm_hit;
      gif = 0; gdm = 0;
      if (bus.if_req_valid_i && if_ok && m_starve == STARVE) gif = 1;
      else if (bus.dm_req_valid_i && dm_ok) gdm = 1;
      else if (bus.if_req_valid_i && if_ok) gif = 1;
      g = gif ? GNT_IF : (gdm ? GNT_DM : GNT_NONE);
      chk("if_ready", bus.if_req_ready_o, gif);
      chk("dm_ready", bus.dm_req_ready_o, gdm);
      chk("grant", bus.gnt_dbg, g);

      if (gif) exp_q.push_back({1'b1, 1'b0, 1'b1, WORD, bus.if_addr_i, DW'(0)});
      if (gdm) exp_q.push_back({!bus.dm_req_is_wr_i, bus.dm_req_is_wr_i, 1'b0,
                                bus.dm_access_size_i, bus.dm_addr_i, bus.dm_wr_data_i});
`ifdef MEM_RSP_TIMEOUT_EN
      if (bus.mem_data_valid_i || (m_if + m_dm) == 0) m_wd = 0;
      else begin
        if (m_wd < TOUT) m_wd++;
        if (m_wd == TOUT) m_err = 1;
      end
`endif
      if (bus.mem_data_valid_i && !if_hit && !dm_hit) m_err = 1;
      m_if = m_if + (gif ? 1 : 0) - (if_hit ? 1 : 0);
      m_dm = m_dm + ((gdm && !bus.dm_req_is_wr_i) ? 1 : 0) - (dm_hit ? 1 : 0);
      if (gdm && bus.if_req_valid_i) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
      else if (gif || !bus.if_req_valid_i) m_starve = 0;
      exp_if_v = if_hit;
      exp_dm_v = dm_hit;
      if (if_hit) exp_if_d = bus.mem_data_i;
      if (dm_hit) exp_dm_d = bus.mem_data_i;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit ifv, input logic [AW-1:0] ifa,
                       input bit dmv, input bit dmw, input logic [AW-1:0] dma,
                       input logic [DW-1:0] dmd, input access_size_t sz,
                       input bit rv, input bit rtag, input logic [DW-1:0] rdat);
    bus.if_req_valid_i      = ifv;
    bus.if_addr_i           = ifa;
    bus.dm_req_valid_i      = dmv;
    bus.dm_req_is_wr_i      = dmw;
    bus.dm_addr_i           = dma;
    bus.dm_wr_data_i        = dmd;
    bus.dm_access_size_i    = sz;
    bus.mem_data_valid_i    = rv;
    bus.mem_data_is_instr_i = rtag;
    bus.mem_data_i          = rdat;
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, '0, '0, WORD, 0, 0, '0);
  endtask

  task automatic rsp(input bit tag, input logic [DW-1:0] d);
    drive(0, '0, 0, 0, '0, '0, WORD, 1, tag, d);
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // IF read alone, then a DM byte read, then one response to each
    drive(1, 32'h4, 0, 0, '0, '0, WORD, 0, 0, '0);
    to_neg();
    chk("t1_if_ready", bus.if_req_ready_o, 1);
    chk("t1_dm_ready", bus.dm_req_ready_o, 0);
    to_drive(); drive(0, '0, 1, 0, 32'h30, '0, BYTE, 0, 0, '0);
    to_neg();
    chk("t1_rd_valid", bus.mem_rd_req_valid_o, 1);
    chk("t1_instr", bus.mem_req_is_instr_o, 1);
    chk("t1_addr", bus.mem_address_o, 32'h4);
    chk("t1_size", bus.mem_access_size_o, WORD);
    to_drive(); idle();
    to_neg();
    chk("t1_dm_addr", bus.mem_address_o, 32'h30);
    chk("t1_dm_size", bus.mem_access_size_o, BYTE);
    chk("t1_dm_instr", bus.mem_req_is_instr_o, 0);
    to_drive(); rsp(1, 32'h4470);
    to_neg();
    to_drive(); rsp(0, 32'h12);
    to_neg();
    chk("t1_if_rsp_v", bus.if_rsp_valid_o, 1);
    chk("t1_if_rsp_d", bus.if_rsp_data_o, 32'h4470);
    to_drive(); idle();
    to_neg();
    chk("t1_dm_rsp_v", bus.dm_rsp_valid_o, 1);
    chk("t1_dm_rsp_d", bus.dm_rsp_data_o, 32'h12);
    chk("t1_err", bus.err_o, 0);

    // DM word write
    to_drive(); drive(0, '0, 1, 1, 32'h20, 32'hDEADBEEF, WORD, 0, 0, '0);
    to_neg();
    chk("t2_dm_ready", bus.dm_req_ready_o, 1);
    to_drive(); idle();
    to_neg();
    chk("t2_wr_valid", bus.mem_wr_req_valid_o, 1);
    chk("t2_rd_valid", bus.mem_rd_req_valid_o, 0);
    chk("t2_wdata", bus.mem_wr_data_o, 32'hDEADBEEF);
    chk("t2_dm_cnt", bus.dm_cnt_dbg, 0);
    to_drive(); idle();
    to_neg();
    chk("t2_no_dm_rsp", bus.dm_rsp_valid_o, 0);

    // IF starved by DM writes: four DM grants, then IF forced
    to_drive(); drive(1, 32'h40, 1, 1, 32'h50, 32'h1234, WORD, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      to_neg();
      chk("t3_if_ready", bus.if_req_ready_o, (i == 4));
      chk("t3_dm_ready", bus.dm_req_ready_o, (i != 4));
      to_drive();
    end
    idle();
    to_neg();
    to_drive(); rsp(1, 32'h77);
    to_neg();

    // Fill IF credits, stall, then accept alongside a response
    to_drive();
    for (int i = 0; i < MAXO; i++) begin
      drive(1, AW'(32'h100 + 4 * i), 0, 0, '0, '0, WORD, 0, 0, '0);
      to_neg();
      chk("t4_fill_ready", bus.if_req_ready_o, 1);
      to_drive();
    end
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("t4_full_ready", bus.if_req_ready_o, 0);
      chk("t4_full_cnt", bus.if_cnt_dbg, MAXO);
      to_drive();
    end
    drive(1, 32'h200, 0, 0, '0, '0, WORD, 1, 1, 32'hA5);
    to_neg();
    chk("t4_rsp_ready", bus.if_req_ready_o, 1);
    to_drive(); idle();
    to_neg();
    chk("t4_cnt_kept", bus.if_cnt_dbg, MAXO);
    for (int i = 0; i < MAXO; i++) begin
      to_drive(); rsp(1, DW'($urandom));
      to_neg();
    end
    to_drive(); idle();
    to_neg();
    chk("t4_drained", bus.if_cnt_dbg, 0);

    // Randomized traffic; the memory only answers clients that have reads in flight
    for (int c = 0; c < 1500; c++) begin
      bit rv, tag;
      to_drive();
      rv = 0; tag = 0;
      if ((m_if > 0 || m_dm > 0) && $urandom_range(0, 99) < 35) begin
        rv = 1;
        if (m_if > 0 && m_dm > 0) tag = 1'($urandom_range(0, 1));
        else tag = (m_if > 0);
      end
      drive($urandom_range(0, 99) < 60, AW'($urandom), $urandom_range(0, 99) < 50,
            1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
            access_size_t'($urandom_range(0, 1)), rv, tag, DW'($urandom));
    end

    // Reset with a requester active: ready must stay low
    to_drive(); drive(1, 32'h8, 0, 0, '0, '0, WORD, 0, 0, '0);
    rst = 1'b1;
    to_neg();
    chk("t5_rst_ready", bus.if_req_ready_o, 0);
    to_drive(); rst = 1'b0; rsp(0, 32'h55);
    to_neg();
    to_drive(); idle();
    to_neg();
    chk("t5_unexp_err", bus.err_o, 1);
    chk("t5_unexp_drop", bus.dm_rsp_valid_o, 0);
    repeat (3) begin
      to_drive(); idle();
      to_neg();
    end
    chk("t5_err_sticky", bus.err_o, 1);

    // Reset while a read is in flight: its late response is unexpected
    to_drive(); rst = 1'b1;
    to_neg();
    to_drive(); rst = 1'b0; drive(1, 32'h8, 0, 0, '0, '0, WORD, 0, 0, '0);
    to_neg();
    to_drive(); idle();
    to_neg();
    chk("t6_err_clear", bus.err_o, 0);
    to_drive(); rst = 1'b1;
    to_neg();
    to_drive(); rst = 1'b0; rsp(1, 32'h99);
    to_neg();
    to_drive(); idle();
    to_neg();
    chk("t6_late_err", bus.err_o, 1);
    chk("t6_late_drop", bus.if_rsp_valid_o, 0);

`ifdef MEM_RSP_TIMEOUT_EN
    // A read that never gets an answer trips the watchdog
    to_drive(); rst = 1'b1;
    to_neg();
    to_drive(); rst = 1'b0; drive(1, 32'hC, 0, 0, '0, '0, WORD, 0, 0, '0);
    to_neg();
    to_drive(); idle();
    repeat (TOUT + 4) to_neg();
    chk("t7_timeout_err", bus.err_o, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
